// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, program-load and SRAM signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              EN;
  logic              TB_LOAD_CTRL;
  logic [ADDR_W-1:0] TB_LOAD_ADDR;
  logic [DATA_W-1:0] TB_LOAD_DATA;
  logic              IF_REQ;
  logic [ADDR_W-1:0] IF_ADDR;
  logic              IF_GNT;
  logic              IF_RVALID;
  logic [DATA_W-1:0] IF_RDATA;
  logic              DM_REQ;
  logic              DM_WE;
  logic [ADDR_W-1:0] DM_ADDR;
  logic [DATA_W-1:0] DM_WDATA;
  logic [3:0]        DM_BE;
  logic              DM_GNT;
  logic              DM_RVALID;
  logic [DATA_W-1:0] DM_RDATA;
  logic              MEM_CSB;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [3:0]        MEM_BE;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              STALL_IF;
  logic              STALL_MEM;
  logic              BUSY;

  modport slave (
    input  EN, TB_LOAD_CTRL, TB_LOAD_ADDR, TB_LOAD_DATA,
    input  IF_REQ, IF_ADDR,
    input  DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BE,
    input  MEM_RDATA,
    output IF_GNT, IF_RVALID, IF_RDATA,
    output DM_GNT, DM_RVALID, DM_RDATA,
    output MEM_CSB, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
    output STALL_IF, STALL_MEM, BUSY
  );

  modport master (
    output EN, TB_LOAD_CTRL, TB_LOAD_ADDR, TB_LOAD_DATA,
    output IF_REQ, IF_ADDR,
    output DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BE,
    output MEM_RDATA,
    input  IF_GNT, IF_RVALID, IF_RDATA,
    input  DM_GNT, DM_RVALID, DM_RDATA,
    input  MEM_CSB, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
    input  STALL_IF, STALL_MEM, BUSY
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port SRAM arbiter: program load > data > fetch, with fetch anti-starvation
module mem_port_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input logic              CLK,
  input logic              RST,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] MAX_B = 4'(MAX_DATA_BURST);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              can_grant, if_gnt, dm_gnt, load_cmd;

  always_comb begin
    load_cmd  = ~RST & bus.TB_LOAD_CTRL;
    can_grant = ~RST & (state_q == RUN) & bus.EN & ~bus.TB_LOAD_CTRL;
    // Once the data streak hits the limit a waiting fetch wins the next slot.
    dm_gnt    = can_grant & bus.DM_REQ & ~(bus.IF_REQ & (streak_q == MAX_B));
    if_gnt    = can_grant & bus.IF_REQ & ~dm_gnt;
  end

  always_comb begin
    bus.MEM_CSB   = 1'b1;
    bus.MEM_WE    = 1'b0;
    bus.MEM_ADDR  = '0;
    bus.MEM_WDATA = '0;
    bus.MEM_BE    = 4'h0;
    if (load_cmd) begin
      bus.MEM_CSB   = 1'b0;
      bus.MEM_WE    = 1'b1;
      bus.MEM_ADDR  = bus.TB_LOAD_ADDR;
      bus.MEM_WDATA = bus.TB_LOAD_DATA;
      bus.MEM_BE    = 4'hF;
    end else if (dm_gnt) begin
      bus.MEM_CSB   = 1'b0;
      bus.MEM_WE    = bus.DM_WE;
      bus.MEM_ADDR  = bus.DM_ADDR;
      bus.MEM_WDATA = bus.DM_WE ? bus.DM_WDATA : '0;
      bus.MEM_BE    = bus.DM_WE ? bus.DM_BE : 4'hF;
    end else if (if_gnt) begin
      bus.MEM_CSB   = 1'b0;
      bus.MEM_ADDR  = bus.IF_ADDR;
      bus.MEM_BE    = 4'hF;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.TB_LOAD_CTRL) state_d = LOAD;
      LOAD:    if (!bus.TB_LOAD_CTRL) state_d = DRAIN;
      DRAIN:   state_d = bus.TB_LOAD_CTRL ? LOAD : RUN;
      default: state_d = RUN;
    endcase

    streak_d = streak_q;
    if (can_grant) begin
      if (!bus.IF_REQ || if_gnt) streak_d = 4'd0;
      else if (dm_gnt && streak_q != MAX_B) streak_d = streak_q + 4'd1;
    end

    if (if_gnt)                     owner_d = OWN_IF;
    else if (dm_gnt && !bus.DM_WE)  owner_d = OWN_DM;
    else                            owner_d = OWN_NONE;

    if_rdata_d = (owner_q == OWN_IF) ? bus.MEM_RDATA : if_rdata_q;
    dm_rdata_d = (owner_q == OWN_DM) ? bus.MEM_RDATA : dm_rdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      owner_q    <= OWN_NONE;
      streak_q   <= 4'd0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Return data is bypassed in the return cycle and held in the _q register afterwards.
  assign bus.IF_GNT    = if_gnt;
  assign bus.DM_GNT    = dm_gnt;
  assign bus.IF_RVALID = ~RST & (owner_q == OWN_IF);
  assign bus.DM_RVALID = ~RST & (owner_q == OWN_DM);
  assign bus.IF_RDATA  = RST ? '0 : if_rdata_d;
  assign bus.DM_RDATA  = RST ? '0 : dm_rdata_d;
  assign bus.STALL_IF  = ~RST & bus.IF_REQ & ~if_gnt;
  assign bus.STALL_MEM = ~RST & bus.DM_REQ & ~dm_gnt;
  assign bus.BUSY      = ~RST & ((state_q != RUN) | (owner_q != OWN_NONE));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter with a behavioural SRAM
module tb_mem_port_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_BURST(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!bus.MEM_CSB) begin
      if (bus.MEM_WE) begin
        for (int b = 0; b < 4; b++)
          if (bus.MEM_BE[b]) sram[bus.MEM_ADDR][8*b +: 8] <= bus.MEM_WDATA[8*b +: 8];
      end else begin
        bus.MEM_RDATA <= sram[bus.MEM_ADDR];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = '0;
    bus.MEM_RDATA    = '0;
    bus.EN           = 1'b1;
    bus.TB_LOAD_CTRL = 1'b0;
    bus.TB_LOAD_ADDR = '0;
    bus.TB_LOAD_DATA = '0;
    bus.IF_REQ       = 1'b1;
    bus.IF_ADDR      = 10'd7;
    bus.DM_REQ       = 1'b0;
    bus.DM_WE        = 1'b0;
    bus.DM_ADDR      = '0;
    bus.DM_WDATA     = '0;
    bus.DM_BE        = 4'h0;

    // Reset held two cycles with a pending fetch
    for (int c = 0; c < 2; c++) begin
      tick(); settle();
      check_eq("rst_csb", 64'(bus.MEM_CSB), 64'd1);
      check_eq("rst_if_gnt", 64'(bus.IF_GNT), 64'd0);
      check_eq("rst_if_rdata", 64'(bus.IF_RDATA), 64'd0);
      check_eq("rst_stall_if", 64'(bus.STALL_IF), 64'd0);
      check_eq("rst_busy", 64'(bus.BUSY), 64'd0);
    end
    tick(); RST = 1'b0; settle();
    check_eq("post_rst_if_gnt", 64'(bus.IF_GNT), 64'd1);
    check_eq("post_rst_addr", 64'(bus.MEM_ADDR), 64'd7);

    // Program load: word 5 and word 3
    tick(); bus.IF_REQ = 1'b0; bus.TB_LOAD_CTRL = 1'b1; bus.TB_LOAD_ADDR = 10'd5; bus.TB_LOAD_DATA = 32'hDEADBEEF; settle();
    check_eq("pre_we", 64'(bus.MEM_WE), 64'd1);
    check_eq("pre_be", 64'(bus.MEM_BE), 64'hF);
    tick(); bus.TB_LOAD_ADDR = 10'd3; bus.TB_LOAD_DATA = 32'hAABBCCDD; settle();
    tick(); bus.TB_LOAD_CTRL = 1'b0; settle();
    tick(); settle();
    check_eq("pre_drain_csb", 64'(bus.MEM_CSB), 64'd1);

    // Single fetch of word 5
    tick(); bus.IF_REQ = 1'b1; bus.IF_ADDR = 10'd5; settle();
    check_eq("f_gnt", 64'(bus.IF_GNT), 64'd1);
    check_eq("f_we", 64'(bus.MEM_WE), 64'd0);
    check_eq("f_be", 64'(bus.MEM_BE), 64'hF);
    tick(); bus.IF_REQ = 1'b0; settle();
    check_eq("f_rvalid", 64'(bus.IF_RVALID), 64'd1);
    check_eq("f_rdata", 64'(bus.IF_RDATA), 64'hDEADBEEF);
    check_eq("f_dm_rvalid", 64'(bus.DM_RVALID), 64'd0);
    check_eq("f_busy", 64'(bus.BUSY), 64'd1);
    tick(); settle();
    check_eq("f_rvalid_pulse", 64'(bus.IF_RVALID), 64'd0);
    check_eq("f_rdata_hold", 64'(bus.IF_RDATA), 64'hDEADBEEF);
    check_eq("f_busy_idle", 64'(bus.BUSY), 64'd0);

    // Contention: expect D,D,D,D,I,D,D,D,D,I
    for (int i = 0; i < 10; i++) begin
      logic exp_d;
      tick(); bus.IF_REQ = 1'b1; bus.DM_REQ = 1'b1; bus.DM_WE = 1'b0; bus.DM_ADDR = 10'd5; settle();
      exp_d = (i % 5) != 4;
      check_eq($sformatf("burst_dm_gnt%0d", i), 64'(bus.DM_GNT), 64'(exp_d));
      check_eq($sformatf("burst_if_gnt%0d", i), 64'(bus.IF_GNT), 64'(!exp_d));
      check_eq($sformatf("burst_stall_if%0d", i), 64'(bus.STALL_IF), 64'(exp_d));
      check_eq($sformatf("burst_stall_mem%0d", i), 64'(bus.STALL_MEM), 64'(!exp_d));
    end
    tick(); bus.IF_REQ = 1'b0; bus.DM_REQ = 1'b0; settle();
    check_eq("burst_last_if_rvalid", 64'(bus.IF_RVALID), 64'd1);
    check_eq("burst_last_dm_rvalid", 64'(bus.DM_RVALID), 64'd0);

    // Partial store then load of word 3
    tick(); bus.DM_REQ = 1'b1; bus.DM_WE = 1'b1; bus.DM_ADDR = 10'd3; bus.DM_WDATA = 32'h11223344; bus.DM_BE = 4'b0011; settle();
    check_eq("st_gnt", 64'(bus.DM_GNT), 64'd1);
    check_eq("st_we", 64'(bus.MEM_WE), 64'd1);
    check_eq("st_be", 64'(bus.MEM_BE), 64'h3);
    check_eq("st_wdata", 64'(bus.MEM_WDATA), 64'h11223344);
    tick(); bus.DM_WE = 1'b0; settle();
    check_eq("st_no_rvalid", 64'(bus.DM_RVALID), 64'd0);
    check_eq("ld_be", 64'(bus.MEM_BE), 64'hF);
    tick(); bus.DM_REQ = 1'b0; settle();
    check_eq("ld_rvalid", 64'(bus.DM_RVALID), 64'd1);
    check_eq("ld_rdata", 64'(bus.DM_RDATA), 64'hAABB3344);

    // Program load of three words while fetch waits
    for (int i = 0; i < 3; i++) begin
      tick(); bus.IF_REQ = 1'b1; bus.IF_ADDR = 10'd9; bus.TB_LOAD_CTRL = 1'b1;
      bus.TB_LOAD_ADDR = 10'(i); bus.TB_LOAD_DATA = 32'h100 + 32'(i); settle();
      check_eq($sformatf("tl_we%0d", i), 64'(bus.MEM_WE), 64'd1);
      check_eq($sformatf("tl_addr%0d", i), 64'(bus.MEM_ADDR), 64'(i));
      check_eq($sformatf("tl_if_gnt%0d", i), 64'(bus.IF_GNT), 64'd0);
      check_eq($sformatf("tl_stall_if%0d", i), 64'(bus.STALL_IF), 64'd1);
    end
    tick(); bus.TB_LOAD_CTRL = 1'b0; settle();
    check_eq("tl_load_if_gnt", 64'(bus.IF_GNT), 64'd0);
    check_eq("tl_load_busy", 64'(bus.BUSY), 64'd1);
    tick(); settle();
    check_eq("tl_drain_if_gnt", 64'(bus.IF_GNT), 64'd0);
    check_eq("tl_drain_csb", 64'(bus.MEM_CSB), 64'd1);
    tick(); settle();
    check_eq("tl_run_if_gnt", 64'(bus.IF_GNT), 64'd1);
    check_eq("tl_sram0", 64'(sram[0]), 64'h100);
    check_eq("tl_sram2", 64'(sram[2]), 64'h102);

    // Reset during an in-flight data load
    tick(); bus.IF_REQ = 1'b0; bus.DM_REQ = 1'b1; bus.DM_WE = 1'b0; bus.DM_ADDR = 10'd5; settle();
    check_eq("rf_gnt", 64'(bus.DM_GNT), 64'd1);
    tick(); bus.DM_REQ = 1'b0; RST = 1'b1; settle();
    check_eq("rf_rvalid_rst", 64'(bus.DM_RVALID), 64'd0);
    check_eq("rf_rdata_rst", 64'(bus.DM_RDATA), 64'd0);
    tick(); RST = 1'b0; settle();
    check_eq("rf_rvalid_after", 64'(bus.DM_RVALID), 64'd0);
    check_eq("rf_rdata_after", 64'(bus.DM_RDATA), 64'd0);

    // Build a streak of 2, stall with EN=0, then resume: D,D,I proves the streak was held
    for (int i = 0; i < 2; i++) begin
      tick(); bus.IF_REQ = 1'b1; bus.DM_REQ = 1'b1; settle();
      check_eq($sformatf("en_pre_dm%0d", i), 64'(bus.DM_GNT), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); bus.EN = 1'b0; settle();
      check_eq($sformatf("en0_dm_gnt%0d", i), 64'(bus.DM_GNT), 64'd0);
      check_eq($sformatf("en0_if_gnt%0d", i), 64'(bus.IF_GNT), 64'd0);
      check_eq($sformatf("en0_stall_if%0d", i), 64'(bus.STALL_IF), 64'd1);
      check_eq($sformatf("en0_stall_mem%0d", i), 64'(bus.STALL_MEM), 64'd1);
      check_eq($sformatf("en0_csb%0d", i), 64'(bus.MEM_CSB), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); bus.EN = 1'b1; settle();
      check_eq($sformatf("en1_dm_gnt%0d", i), 64'(bus.DM_GNT), 64'(i != 2));
      check_eq($sformatf("en1_if_gnt%0d", i), 64'(bus.IF_GNT), 64'(i == 2));
    end
    tick(); bus.IF_REQ = 1'b0; bus.DM_REQ = 1'b0; settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
